// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential front end for the combinational 32-bit ALU.
//
// Accepts one R-type operation (MIPS funct + two signed operands) on an
// in_valid/in_ready handshake, maps the funct onto ALU sel/control, drives the
// ALU from registered operands, captures alu_res and returns it on an
// out_valid/out_ready handshake. Multiply/divide hold the ALU inputs for
// MULDIV_CYCLES cycles before capture. Illegal functs skip the ALU and
// complete with out_err=1, out_res=0.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         operation handshake; in_ready high only when idle
//   in_funct, in_a, in_b      funct code and operands
//   alu_a, alu_b              registered operands to the ALU
//   alu_sel, alu_control      ALU select; control=1 selects set-less-than
//   alu_res                   ALU result
//   out_valid/out_ready       result handshake
//   out_res, out_zero, out_err captured result, result==0, illegal/trap flag
//
// Optional feature macro: DIV_ZERO_TRAP_EN -- when defined, a div with
// in_b==0 is not issued and completes immediately with out_err=1.

module alu_issue_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_control,
  input  logic [31:0] alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_zero,
  output logic        out_err
);

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnDiv  = 6'b011010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;

  localparam logic [3:0] CntLoad = 4'(MULDIV_CYCLES);

  typedef enum logic [1:0] {StIdle, StExec, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_sel_q, alu_sel_d;
  logic        alu_ctrl_q, alu_ctrl_d;
  logic [31:0] out_res_q, out_res_d;
  logic        out_zero_q, out_zero_d;
  logic        out_err_q, out_err_d;

  // Funct decode
  logic       dec_legal;
  logic       dec_muldiv;
  logic [2:0] dec_sel;
  logic       dec_ctrl;
  logic       div_trap;

  always_comb begin
    dec_legal  = 1'b1;
    dec_muldiv = 1'b0;
    dec_sel    = 3'b000;
    dec_ctrl   = 1'b0;
    case (in_funct)
      FnAdd:  dec_sel = 3'b000;
      FnSub:  dec_sel = 3'b001;
      FnSlt:  begin dec_sel = 3'b001; dec_ctrl = 1'b1; end
      FnMult: begin dec_sel = 3'b010; dec_muldiv = 1'b1; end
      FnDiv:  begin dec_sel = 3'b011; dec_muldiv = 1'b1; end
      FnAnd:  dec_sel = 3'b100;
      FnOr:   dec_sel = 3'b101;
      FnXor:  dec_sel = 3'b110;
      FnNor:  dec_sel = 3'b111;
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef DIV_ZERO_TRAP_EN
  assign div_trap = (in_funct == FnDiv) && (in_b == 32'd0);
`else
  assign div_trap = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    alu_ctrl_d = alu_ctrl_q;
    out_res_d  = out_res_q;
    out_zero_d = out_zero_q;
    out_err_d  = out_err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!dec_legal || div_trap) begin
            // Not issued: ALU registers keep the previous operation.
            out_res_d  = 32'd0;
            out_zero_d = 1'b1;
            out_err_d  = 1'b1;
            state_d    = StDone;
          end else begin
            alu_a_d    = in_a;
            alu_b_d    = in_b;
            alu_sel_d  = dec_sel;
            alu_ctrl_d = dec_ctrl;
            if (dec_muldiv) begin
              cnt_d   = CntLoad;
              state_d = StWait;
            end else begin
              state_d = StExec;
            end
          end
        end
      end
      StExec: begin
        out_res_d  = alu_res;
        out_zero_d = (alu_res == 32'd0);
        out_err_d  = 1'b0;
        state_d    = StDone;
      end
      StWait: begin
        // <= 1 also recovers if the counter were somehow zero.
        if (cnt_q <= 4'd1) begin
          out_res_d  = alu_res;
          out_zero_d = (alu_res == 32'd0);
          out_err_d  = 1'b0;
          cnt_d      = 4'd0;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      alu_a_q    <= 32'd0;
      alu_b_q    <= 32'd0;
      alu_sel_q  <= 3'b000;
      alu_ctrl_q <= 1'b0;
      out_res_q  <= 32'd0;
      out_zero_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      alu_ctrl_q <= alu_ctrl_d;
      out_res_q  <= out_res_d;
      out_zero_q <= out_zero_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign alu_control = alu_ctrl_q;
  assign out_res     = out_res_q;
  assign out_zero    = out_zero_q;
  assign out_err     = out_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed cases plus randomized operations
// compared against a funct-level reference model. A behavioural ALU closes
// the loop on alu_a/alu_b/alu_sel/alu_control -> alu_res.

module tb_alu_issue_ctrl;

  localparam int unsigned Mc = 4;
  localparam logic [31:0] DivZeroVal = 32'hDEAD_BEEF;
`ifdef DIV_ZERO_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_sel;
  logic        alu_control;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic        out_zero, out_err;

  alu_issue_ctrl #(.MULDIV_CYCLES(Mc)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_control(alu_control),
    .alu_res    (alu_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_zero   (out_zero),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_res = 32'd0;
    case (alu_sel)
      3'd0: alu_res = alu_a + alu_b;
      3'd1: alu_res = alu_control ? {31'd0, $signed(alu_a) < $signed(alu_b)} : alu_a - alu_b;
      3'd2: alu_res = $signed(alu_a) * $signed(alu_b);
      3'd3: alu_res = (alu_b == 32'd0) ? DivZeroVal : $signed(alu_a) / $signed(alu_b);
      3'd4: alu_res = alu_a & alu_b;
      3'd5: alu_res = alu_a | alu_b;
      3'd6: alu_res = alu_a ^ alu_b;
      default: alu_res = ~(alu_a | alu_b);
    endcase
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: last issued ALU drive
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic [3:0]  m_selctl = 4'd0;  // {control, sel}

  // Returns {legal, control, sel}
  function automatic logic [4:0] decode(input logic [5:0] f);
    case (f)
      6'b100000: return 5'b1_0_000;
      6'b100010: return 5'b1_0_001;
      6'b101010: return 5'b1_1_001;
      6'b011000: return 5'b1_0_010;
      6'b011010: return 5'b1_0_011;
      6'b100100: return 5'b1_0_100;
      6'b100101: return 5'b1_0_101;
      6'b100110: return 5'b1_0_110;
      6'b100111: return 5'b1_0_111;
      default:   return 5'b0_0_000;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [5:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (f)
      6'b100000: r = a + b;
      6'b100010: r = a - b;
      6'b101010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b011000: r = $signed(a) * $signed(b);
      6'b011010: r = (b == 32'd0) ? DivZeroVal : $signed(a) / $signed(b);
      6'b100100: r = a & b;
      6'b100101: r = a | b;
      6'b100110: r = a ^ b;
      6'b100111: r = ~(a | b);
      default:   r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic check_alu_hold(input string tag);
    check({tag, " alu_a"}, alu_a, m_a);
    check({tag, " alu_b"}, alu_b, m_b);
    check({tag, " alu_sel"}, {28'd0, alu_control, alu_sel}, {28'd0, m_selctl});
  endtask

  task automatic check_reset_vals();
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_res", out_res, 32'd0);
    check("rst out_zero", {31'd0, out_zero}, 32'd0);
    check("rst out_err", {31'd0, out_err}, 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_sel", {28'd0, alu_control, alu_sel}, 32'd0);
  endtask

  // One full transaction; hold = cycles out_ready stays low once out_valid rises.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [4:0]  d;
    bit          issued, is_md;
    int          exp_lat, edges;
    logic [31:0] exp_res, res_seen;
    logic        exp_err;

    d       = decode(f);
    issued  = d[4] && !(Trap && f == 6'b011010 && b == 32'd0);
    is_md   = (f == 6'b011000) || (f == 6'b011010);
    exp_err = !issued;
    exp_res = issued ? ref_res(f, a, b) : 32'd0;
    exp_lat = !issued ? 1 : (is_md ? 1 + Mc : 2);

    @(negedge clk);
    check("in_ready idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_funct = f; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (issued) begin
      m_a = a; m_b = b; m_selctl = d[3:0];
    end
    check_alu_hold("accept");
    edges = 1;
    while (!out_valid && edges < 40) begin
      check("in_ready busy", {31'd0, in_ready}, 32'd0);
      // Busy-time noise that must be ignored
      in_valid = 1'($urandom); in_funct = 6'($urandom); in_a = $urandom; in_b = $urandom;
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      edges++;
      check_alu_hold("busy");
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (!out_valid) begin
      check("out_valid timeout", 32'd0, 32'd1);
      rst = 1'b1; #2; rst = 1'b0;
      m_a = 32'd0; m_b = 32'd0; m_selctl = 4'd0;
      return;
    end
    check("latency", edges, exp_lat);
    check("out_res", out_res, exp_res);
    check("out_zero", {31'd0, out_zero}, {31'd0, exp_res == 32'd0});
    check("out_err", {31'd0, out_err}, {31'd0, exp_err});
    res_seen = out_res;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold out_valid", {31'd0, out_valid}, 32'd1);
      check("hold out_res", out_res, res_seen);
      check_alu_hold("hold");
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post out_valid", {31'd0, out_valid}, 32'd0);
    check("post in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  localparam logic [5:0] Legal [9] = '{6'b100000, 6'b100010, 6'b101010, 6'b011000,
                                       6'b011010, 6'b100100, 6'b100101, 6'b100110,
                                       6'b100111};

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;

    rst = 1'b1; in_valid = 1'b0; in_funct = 6'd0; in_a = 32'd0; in_b = 32'd0;
    out_ready = 1'b0;
    #12;
    check_reset_vals();
    @(negedge clk); rst = 1'b0;

    // Directed cases
    run_op(6'b100000, 32'd5, 32'd7, 0);
    run_op(6'b101010, -32'sd3, 32'd2, 0);
    run_op(6'b100010, 32'd9, 32'd9, 1);
    run_op(6'b011000, 32'd6, 32'd7, 3);
    run_op(6'b111111, 32'd1, 32'd2, 0);
    run_op(6'b011010, 32'd10, 32'd0, 0);
    run_op(6'b011010, -32'sd20, 32'd3, 2);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        f = 6'($urandom);
        while (decode(f)[4]) f = 6'($urandom);
      end else begin
        f = Legal[$urandom_range(0, 8)];
      end
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = $urandom_range(0, 20) - 10; b = $urandom_range(0, 20) - 10; end
        default: ;
      endcase
      if (f == 6'b011010 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      run_op(f, a, b, $urandom_range(0, 3));
    end

    // Reset mid-operation during a divide's wait window
    @(negedge clk);
    in_valid = 1'b1; in_funct = 6'b011010; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_vals();
    m_a = 32'd0; m_b = 32'd0; m_selctl = 4'd0;
    @(negedge clk); rst = 1'b0;
    repeat (Mc + 2) begin
      @(posedge clk); #1;
      check("no out_valid after rst", {31'd0, out_valid}, 32'd0);
    end
    run_op(6'b100110, 32'h0000_00F0, 32'h0000_00FF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
